// File: rtl/mdu_pkg.sv
// ============================================================================
// Module   : mdu_pkg
// Purpose  : Shared op encodings, FSM states and iteration count for the MDU.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mdu_pkg;

    localparam int ITER_COUNT = 32;
    localparam int CNT_W      = 6;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_e;

    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_addsub.sv
// ============================================================================
// Module   : mdu_addsub
// Purpose  : 33-bit add/subtract step shared by multiply and divide iterations.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mdu_addsub (
    input  logic [32:0] a,
    input  logic [32:0] b,
    input  logic        sub,
    output logic [32:0] sum
);

    assign sum = sub ? (a - b) : (a + b);

endmodule

`default_nettype wire

// File: rtl/mult_div_unit.sv
// ============================================================================
// Module   : mult_div_unit
// Purpose  : Iterative radix-2 multiply/divide unit with HI/LO registers.
//            Macro MDU_DIV_EN compiles in the divide path (div/divu).
// Revision : 1.0
// ============================================================================
`default_nettype none

module mult_div_unit
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic        mthi,
    input  logic        mtlo,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER_COUNT - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    op_e                op_q, op_d;
    logic               sa_q, sa_d;
    logic               sb_q, sb_d;
    logic [31:0]        acc_q, acc_d;
    logic [31:0]        work_q, work_d;
    logic [31:0]        opnd_q, opnd_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [32:0]        as_a;
    logic [32:0]        as_b;
    logic               as_sub;
    logic [32:0]        as_sum;
    logic               w_start_ok;
    logic               w_sgn;
    logic [63:0]        w_prod;

`ifdef MDU_DIV_EN
    logic               w_mult;
    logic               w_div0;
    logic               w_borrow;

    assign w_start_ok = 1'b1;
    assign w_mult     = (op_q == OP_MULT) || (op_q == OP_MULTU);
    assign w_div0     = (opnd_q == 32'd0);
    // A zero divisor never borrows, so the dividend shifts into acc unchanged.
    assign w_borrow   = as_sum[32] & ~w_div0;
`else
    assign w_start_ok = (op == OP_MULT) || (op == OP_MULTU);
`endif

    assign w_sgn = ~op[0];

    mdu_addsub u_addsub (
        .a   (as_a),
        .b   (as_b),
        .sub (as_sub),
        .sum (as_sum)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        acc_d   = acc_q;
        work_d  = work_q;
        opnd_d  = opnd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        w_prod  = {acc_q, work_q};

        as_a    = {1'b0, acc_q};
        as_b    = {1'b0, (work_q[0] ? opnd_q : 32'd0)};
        as_sub  = 1'b0;
`ifdef MDU_DIV_EN
        if (!w_mult) begin
            as_a   = {acc_q, work_q[31]};
            as_b   = {1'b0, opnd_q};
            as_sub = 1'b1;
        end
`endif

        case (state_q)
            S_CALC: begin
                cnt_d  = cnt_q + 1'b1;
                acc_d  = as_sum[32:1];
                work_d = {as_sum[0], work_q[31:1]};
`ifdef MDU_DIV_EN
                if (!w_mult) begin
                    acc_d  = w_borrow ? as_a[31:0] : as_sum[31:0];
                    work_d = {work_q[30:0], ~w_borrow};
                end
`endif
                if (cnt_q == LAST_ITER) begin
                    cnt_d   = '0;
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (sa_q ^ sb_q) begin
                    w_prod = ~w_prod + 64'd1;
                end
                hi_d = w_prod[63:32];
                lo_d = w_prod[31:0];
`ifdef MDU_DIV_EN
                if (!w_mult) begin
                    hi_d = magnitude(acc_q, sa_q);
                    lo_d = magnitude(work_q, (sa_q ^ sb_q) & ~w_div0);
                end
`endif
                state_d = S_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: begin
                // IDLE and DONE behave alike: start wins over mthi/mtlo.
                state_d = S_IDLE;
                if (start) begin
                    if (w_start_ok) begin
                        state_d = S_CALC;
                        busy_d  = 1'b1;
                        cnt_d   = '0;
                        op_d    = op_e'(op);
                        sa_d    = w_sgn & in1[31];
                        sb_d    = w_sgn & in2[31];
                        acc_d   = 32'd0;
                        work_d  = magnitude(in1, w_sgn & in1[31]);
                        opnd_d  = magnitude(in2, w_sgn & in2[31]);
                    end
                end else begin
                    if (mthi) hi_d = in1;
                    if (mtlo) lo_d = in1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_MULT;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            acc_q   <= 32'd0;
            work_q  <= 32'd0;
            opnd_q  <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            acc_q   <= acc_d;
            work_q  <= work_d;
            opnd_q  <= opnd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// ============================================================================
// Module   : tb_mult_div_unit
// Purpose  : Scoreboard bench for mult_div_unit (divide cases need MDU_DIV_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mult_div_unit;

    localparam logic [1:0] C_MULT  = 2'b00;
    localparam logic [1:0] C_MULTU = 2'b01;
    localparam logic [1:0] C_DIV   = 2'b10;
    localparam logic [1:0] C_DIVU  = 2'b11;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op    = 2'b00;
    logic [31:0] in1   = 32'd0;
    logic [31:0] in2   = 32'd0;
    logic        mthi  = 1'b0;
    logic        mtlo  = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    mult_div_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .in1   (in1),
        .in2   (in2),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check("done_without_op", {31'd0, done}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.name, " hi"}, hi, e.hi);
                check({e.name, " lo"}, lo, e.lo);
            end
        end
    end

    task automatic wait_done(input string name, output int lat);
        lat = 1;
        @(posedge clk); #1;
        start = 1'b0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        while (!done && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, " done_seen"}, {31'd0, done}, 32'd1);
    endtask

    task automatic run(input string name, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                       input bit b2b, input bit with_mtlo, output int lat);
        exp_t e;
        if (!b2b) begin
            @(posedge clk); #1;
        end
        e.name = name;
        e.hi   = eh;
        e.lo   = el;
        exp_q.push_back(e);
        op    = o;
        in1   = a;
        in2   = b;
        start = 1'b1;
        mtlo  = with_mtlo;
        wait_done(name, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int lat;

        repeat (3) @(posedge clk);
        #1;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        rst_n = 1'b1;

        run("multu max", C_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0, 0, lat);
        check("multu latency", lat, 34);
        run("mult -3x5", C_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1, 0, lat);
        run("mult min^2", C_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1, 0, lat);
        run("mult 7x-6", C_MULT, 32'd7, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6, 0, 0, lat);

        @(posedge clk); #1;
        in1 = 32'h00001234; mthi = 1'b1;
        @(posedge clk); #1;
        mthi = 1'b0;
        check("mthi hi", hi, 32'h00001234);
        check("mthi lo_kept", lo, 32'hFFFFFFD6);
        in1 = 32'h00005678; mtlo = 1'b1;
        @(posedge clk); #1;
        mtlo = 1'b0;
        check("mtlo lo", lo, 32'h00005678);
        check("mtlo hi_kept", hi, 32'h00001234);

        run("multu 2x3 with mtlo", C_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 0, 1, lat);

        // Stray start and mthi at cycle 5 of a busy operation must be ignored.
        begin
            exp_t e;
            @(posedge clk); #1;
            e.name = "mult 100x3 busy_ignore";
            e.hi   = 32'd0;
            e.lo   = 32'd300;
            exp_q.push_back(e);
            op = C_MULT; in1 = 32'd100; in2 = 32'd3; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            repeat (4) @(posedge clk);
            #1;
            check("busy at cycle 5", {31'd0, busy}, 32'd1);
            op = C_MULTU; in1 = 32'h0000DEAD; in2 = 32'd9; start = 1'b1; mthi = 1'b1;
            wait_done("mult 100x3 busy_ignore", lat);
            repeat (3) @(posedge clk);
            #1;
            check("busy after single op", {31'd0, busy}, 32'd0);
        end

`ifdef MDU_DIV_EN
        run("div -7/2", C_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 0, lat);
        run("divu 7/0", C_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF, 1, 0, lat);
        check("divu div0 latency", lat, 34);
        run("div min/-1", C_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0, 0, lat);
        run("divu 100/7", C_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 0, 0, lat);
`else
        @(posedge clk); #1;
        op = C_DIV; in1 = 32'd7; in2 = 32'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("div disabled busy", {31'd0, busy}, 32'd0);
        check("div disabled hi", hi, 32'd0);
        check("div disabled lo", lo, 32'd300);
`endif

        // Reset in the middle of an operation: no result, no done pulse.
        @(posedge clk); #1;
`ifdef MDU_DIV_EN
        op = C_DIVU;
`else
        op = C_MULTU;
`endif
        in1 = 32'd1000; in2 = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("busy before abort", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        check("abort hi", hi, 32'd0);
        check("abort lo", lo, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        check("post-abort busy", {31'd0, busy}, 32'd0);
        check("post-abort hi", hi, 32'd0);
        check("scoreboard empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
